// File: rtl/io_pkg.sv
// Shared constants for the I/O port bank: stall/overwrite mode encoding,
// port-count limit and status-word field placement.
package io_pkg;

    localparam int MAX_PORTS = 8;

    typedef enum logic {
        BLK_OVERWRITE = 1'b0,
        BLK_STALL     = 1'b1
    } blk_mode_e;

    // Status word layout, LSB first: out_valid, out_ovr, in_full, in_ovr.
    function automatic int stat_oovr_off(input int n_out);
        return n_out;
    endfunction

    function automatic int stat_full_off(input int n_out);
        return 2 * n_out;
    endfunction

    function automatic int stat_iovr_off(input int n_out, input int n_in);
        return 2 * n_out + n_in;
    endfunction

    function automatic int stat_width(input int n_out, input int n_in);
        return 2 * (n_out + n_in);
    endfunction

endpackage

// File: rtl/in_capture.sv
// One strobed input channel: 2-FF strobe synchroniser, rising-edge capture
// into a holding register, full and sticky overrun flags.
module in_capture
    import io_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strobe,
    input  logic [DATA_W-1:0] data,
    input  logic              consume,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] hold,
    output logic              full,
    output logic              ovr
);

    logic [2:0]        sync_q, sync_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              full_q, full_d;
    logic              ovr_q, ovr_d;
    logic              capture;

    // sync_q[1] is the synchronised strobe; sync_q[2] is its previous value.
    always_comb begin
        sync_d  = {sync_q[1:0], strobe};
        capture = sync_q[1] & ~sync_q[2];
        hold_d  = hold_q;
        full_d  = full_q;
        ovr_d   = ovr_clr ? 1'b0 : ovr_q;
        if (capture) begin
            if (!full_q || consume) begin
                hold_d = data;
                full_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (consume) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hold_q <= '0;
            full_q <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hold_q <= hold_d;
            full_q <= full_d;
            ovr_q  <= ovr_d;
        end
    end

    assign hold = hold_q;
    assign full = full_q;
    assign ovr  = ovr_q;

endmodule

// File: rtl/io_port_bank.sv
// CPU-bus I/O unit: N_OUT handshaked output ports, N_IN strobed input ports
// and a pollable status word.
module io_port_bank
    import io_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int BUS_W    = 16,
    parameter int N_OUT    = 2,
    parameter int N_IN     = 2,
    parameter int BLOCKING = 1,
    parameter int SEL_W    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SEL_W-1:0]        port_sel,
    input  logic                    out_we,
    input  logic                    in_oe,
    input  logic                    stat_oe,
    input  logic [BUS_W-1:0]        bus_in,
    output logic [BUS_W-1:0]        bus_out,
    output logic                    stall,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ack,
    input  logic [N_IN*DATA_W-1:0]  in_data,
    input  logic [N_IN-1:0]         in_strobe
);

    localparam bit STALL_MODE = (BLOCKING == int'(BLK_STALL));
    localparam int STAT_W     = stat_width(N_OUT, N_IN);
    localparam int OOVR_OFF   = stat_oovr_off(N_OUT);
    localparam int FULL_OFF   = stat_full_off(N_OUT);
    localparam int IOVR_OFF   = stat_iovr_off(N_OUT, N_IN);

    logic                    stat_rd;
    logic [N_OUT-1:0]        we_hit;
    logic [N_OUT-1:0]        busy;
    logic [N_OUT-1:0]        out_valid_q;
    logic [N_OUT-1:0]        out_ovr_q;
    logic [N_IN-1:0]         in_consume;
    logic [N_IN-1:0]         in_full;
    logic [N_IN-1:0]         in_ovr;
    logic [DATA_W-1:0]       in_hold [N_IN];
    logic [STAT_W-1:0]       stat_word;

    // A status read only counts when no input read claims the bus.
    assign stat_rd = stat_oe & ~in_oe;

    generate
        if (DATA_W < BUS_W) begin : g_bus_hi
            logic unused_bus_hi;
            assign unused_bus_hi = ^bus_in[BUS_W-1:DATA_W];
        end
    endgenerate

    for (genvar p = 0; p < N_OUT; p++) begin : g_out
        logic [DATA_W-1:0] data_q, data_d;
        logic              valid_q, valid_d;
        logic              ovr_q, ovr_d;

        assign we_hit[p] = out_we && (port_sel == SEL_W'(p));
        assign busy[p]   = valid_q & ~out_ack[p];

        // Overwrite mode accepts into a busy port and records the overrun.
        always_comb begin
            data_d  = data_q;
            valid_d = valid_q;
            ovr_d   = stat_rd ? 1'b0 : ovr_q;
            if (we_hit[p] && (!busy[p] || !STALL_MODE)) begin
                data_d  = bus_in[DATA_W-1:0];
                valid_d = 1'b1;
                if (busy[p]) begin
                    ovr_d = 1'b1;
                end
            end else if (out_ack[p]) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
                ovr_q   <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
                ovr_q   <= ovr_d;
            end
        end

        assign out_valid_q[p]                = valid_q;
        assign out_ovr_q[p]                  = ovr_q;
        assign out_data[p*DATA_W +: DATA_W]  = data_q;
    end

    for (genvar q = 0; q < N_IN; q++) begin : g_in
        assign in_consume[q] = in_oe && (port_sel == SEL_W'(q));

        in_capture #(
            .DATA_W (DATA_W)
        ) u_cap (
            .clk     (clk),
            .rst     (rst),
            .strobe  (in_strobe[q]),
            .data    (in_data[q*DATA_W +: DATA_W]),
            .consume (in_consume[q]),
            .ovr_clr (stat_rd),
            .hold    (in_hold[q]),
            .full    (in_full[q]),
            .ovr     (in_ovr[q])
        );
    end

    assign out_valid = out_valid_q;
    assign stall     = STALL_MODE && |(we_hit & busy);

    always_comb begin
        stat_word                      = '0;
        stat_word[0 +: N_OUT]          = out_valid_q;
        stat_word[OOVR_OFF +: N_OUT]   = out_ovr_q;
        stat_word[FULL_OFF +: N_IN]    = in_full;
        stat_word[IOVR_OFF +: N_IN]    = in_ovr;
    end

    // Out-of-range port_sel leaves bus_out at zero.
    always_comb begin
        bus_out = '0;
        if (in_oe) begin
            for (int q = 0; q < N_IN; q++) begin
                if (port_sel == SEL_W'(q)) begin
                    bus_out[DATA_W-1:0] = in_hold[q];
                end
            end
        end else if (stat_oe) begin
            bus_out[STAT_W-1:0] = stat_word;
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// Bench for io_port_bank: one stalling and one overwriting instance share the
// stimulus; a behavioural model is compared every cycle plus literal checks.
module tb_io_port_bank;

    localparam int DW = 8;
    localparam int BW = 16;
    localparam int NO = 2;
    localparam int NI = 2;
    localparam int SW = 3;

    logic            clk;
    logic            rst;
    logic [SW-1:0]   port_sel;
    logic            out_we, in_oe, stat_oe;
    logic [BW-1:0]   bus_in;
    logic [NO-1:0]   out_ack;
    logic [NI*DW-1:0] in_data;
    logic [NI-1:0]   in_strobe;

    logic [BW-1:0]    bus_out_b, bus_out_o;
    logic             stall_b, stall_o;
    logic [NO*DW-1:0] out_data_b, out_data_o;
    logic [NO-1:0]    out_valid_b, out_valid_o;

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    io_port_bank #(.DATA_W(DW), .BUS_W(BW), .N_OUT(NO), .N_IN(NI), .BLOCKING(1), .SEL_W(SW)) dut_b (
        .clk(clk), .rst(rst), .port_sel(port_sel), .out_we(out_we), .in_oe(in_oe),
        .stat_oe(stat_oe), .bus_in(bus_in), .bus_out(bus_out_b), .stall(stall_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ack(out_ack),
        .in_data(in_data), .in_strobe(in_strobe));

    io_port_bank #(.DATA_W(DW), .BUS_W(BW), .N_OUT(NO), .N_IN(NI), .BLOCKING(0), .SEL_W(SW)) dut_o (
        .clk(clk), .rst(rst), .port_sel(port_sel), .out_we(out_we), .in_oe(in_oe),
        .stat_oe(stat_oe), .bus_in(bus_in), .bus_out(bus_out_o), .stall(stall_o),
        .out_data(out_data_o), .out_valid(out_valid_o), .out_ack(out_ack),
        .in_data(in_data), .in_strobe(in_strobe));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Model state; index 0 = overwrite instance, 1 = stalling instance.
    logic [DW-1:0] m_odata [2][NO];
    logic          m_oval  [2][NO];
    logic          m_oovr  [2][NO];
    logic [DW-1:0] m_hold  [NI];
    logic          m_full  [NI];
    logic          m_iovr  [NI];
    int            shist   [NI][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < NO; p++) begin
                m_odata[m][p] = '0; m_oval[m][p] = 0; m_oovr[m][p] = 0;
            end
        for (int q = 0; q < NI; q++) begin
            m_hold[q] = '0; m_full[q] = 0; m_iovr[q] = 0; shist[q].delete();
        end
    endtask

    task automatic model_step();
        bit stat_rd, hit, busy, set, cap, consume;
        stat_rd = stat_oe && !in_oe;
        for (int m = 0; m < 2; m++)
            for (int p = 0; p < NO; p++) begin
                hit  = out_we && (int'(port_sel) == p);
                busy = m_oval[m][p] && !out_ack[p];
                set  = 0;
                if (hit && (!busy || m == 0)) begin
                    m_odata[m][p] = bus_in[DW-1:0];
                    m_oval[m][p]  = 1;
                    set = busy;
                end else if (out_ack[p]) begin
                    m_oval[m][p] = 0;
                end
                m_oovr[m][p] = (stat_rd ? 1'b0 : m_oovr[m][p]) | set;
            end
        for (int q = 0; q < NI; q++) begin
            // Capture when the strobe, seen two edges back, had just risen.
            cap = (shist[q].size() > 1 && shist[q][1] == 1) &&
                  !(shist[q].size() > 2 && shist[q][2] == 1);
            consume = in_oe && (int'(port_sel) == q);
            set = 0;
            if (cap) begin
                if (!m_full[q] || consume) begin
                    m_hold[q] = in_data[q*DW +: DW];
                    m_full[q] = 1;
                end else begin
                    set = 1;
                end
            end else if (consume) begin
                m_full[q] = 0;
            end
            m_iovr[q] = (stat_rd ? 1'b0 : m_iovr[q]) | set;
            shist[q].push_front(int'(in_strobe[q]));
            if (shist[q].size() > 4) void'(shist[q].pop_back());
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    function automatic logic [BW-1:0] exp_bus(input int m);
        logic [BW-1:0] w;
        w = '0;
        if (in_oe) begin
            if (int'(port_sel) < NI) w[DW-1:0] = m_hold[port_sel];
        end else if (stat_oe) begin
            for (int p = 0; p < NO; p++) begin
                w[p]      = m_oval[m][p];
                w[NO + p] = m_oovr[m][p];
            end
            for (int q = 0; q < NI; q++) begin
                w[2*NO + q]      = m_full[q];
                w[2*NO + NI + q] = m_iovr[q];
            end
        end
        return w;
    endfunction

    function automatic logic exp_stall(input int m);
        if (m == 1 && out_we && int'(port_sel) < NO)
            return m_oval[1][port_sel] && !out_ack[port_sel];
        return 1'b0;
    endfunction

    function automatic logic [NO*DW-1:0] exp_odata(input int m);
        logic [NO*DW-1:0] v;
        for (int p = 0; p < NO; p++) v[p*DW +: DW] = m_odata[m][p];
        return v;
    endfunction

    function automatic logic [NO-1:0] exp_oval(input int m);
        logic [NO-1:0] v;
        for (int p = 0; p < NO; p++) v[p] = m_oval[m][p];
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("blk out_data",  32'(out_data_b),  32'(exp_odata(1)));
            check("blk out_valid", 32'(out_valid_b), 32'(exp_oval(1)));
            check("blk bus_out",   32'(bus_out_b),   32'(exp_bus(1)));
            check("blk stall",     32'(stall_b),     32'(exp_stall(1)));
            check("ovw out_data",  32'(out_data_o),  32'(exp_odata(0)));
            check("ovw out_valid", 32'(out_valid_o), 32'(exp_oval(0)));
            check("ovw bus_out",   32'(bus_out_o),   32'(exp_bus(0)));
            check("ovw stall",     32'(stall_o),     32'(exp_stall(0)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; port_sel = '0; out_we = 0; in_oe = 0; stat_oe = 0;
        bus_in = '0; out_ack = '0; in_data = '0; in_strobe = '0;
        model_reset();
        #1;
        chk_en = 1;
        check("reset bus_out", 32'(bus_out_b), 32'h0);
        check("reset stall", 32'(stall_b), 32'h0);
        check("reset out_valid", 32'(out_valid_b), 32'h0);
        repeat (2) tick();
        rst = 0;
        tick();

        // Plain write and ack on port 0
        out_we = 1; port_sel = 0; bus_in = 16'h00A5;
        tick();
        out_we = 0;
        check("wr p0 data", 32'(out_data_b[7:0]), 32'hA5);
        check("wr p0 valid", 32'(out_valid_b), 32'h1);
        out_ack = 2'b01;
        tick();
        out_ack = 2'b00;
        check("ack p0 valid", 32'(out_valid_b), 32'h0);

        // Busy port 1: stall vs overwrite, then ack releases the stall
        out_we = 1; port_sel = 1; bus_in = 16'h0011;
        tick();
        bus_in = 16'h003C;
        #1;
        check("busy stall blk", 32'(stall_b), 32'h1);
        check("busy stall ovw", 32'(stall_o), 32'h0);
        tick();
        check("stalled p1 data", 32'(out_data_b[15:8]), 32'h11);
        check("ovw p1 data", 32'(out_data_o[15:8]), 32'h3C);
        out_ack = 2'b10;
        #1;
        check("ack clears stall", 32'(stall_b), 32'h0);
        tick();
        out_we = 0; out_ack = 2'b00;
        check("accepted p1 data", 32'(out_data_b[15:8]), 32'h3C);
        check("accepted p1 valid", 32'(out_valid_b[1]), 32'h1);

        // Overwrite busy port 0 and read overrun status
        out_we = 1; port_sel = 0; bus_in = 16'h0012;
        tick();
        bus_in = 16'h0077;
        tick();
        out_we = 0;
        check("ovw p0 data", 32'(out_data_o[7:0]), 32'h77);
        check("blk p0 kept", 32'(out_data_b[7:0]), 32'h12);
        stat_oe = 1;
        #1;
        check("ovw status", 32'(bus_out_o), 32'h000F);
        check("blk status", 32'(bus_out_b), 32'h0003);
        tick();
        check("ovw status reread", 32'(bus_out_o), 32'h0003);
        stat_oe = 0;
        out_ack = 2'b11;
        tick();
        out_ack = 2'b00;

        // Input port 1: capture latency, then overrun on second strobe
        in_data = 16'h5A00; in_strobe = 2'b10;
        tick(); tick();
        stat_oe = 1;
        #1;
        check("in_full not yet", 32'(bus_out_b), 32'h0000);
        tick();
        check("in_full third edge", 32'(bus_out_b), 32'h0020);
        stat_oe = 0; in_strobe = 2'b00;
        tick(); tick();
        in_data = 16'h6600; in_strobe = 2'b10;
        repeat (3) tick();
        in_strobe = 2'b00;
        in_oe = 1; port_sel = 1;
        #1;
        check("read in1 old", 32'(bus_out_b), 32'h005A);
        tick();
        in_oe = 0; stat_oe = 1;
        #1;
        check("in_ovr status", 32'(bus_out_b), 32'h0080);
        tick();
        check("in_ovr cleared", 32'(bus_out_b), 32'h0000);
        stat_oe = 0;

        // Read and capture on the same edge for input port 0
        in_data = 16'h00C3; in_strobe = 2'b01;
        repeat (3) tick();
        in_strobe = 2'b00;
        tick(); tick();
        in_data = 16'h00D4; in_strobe = 2'b01;
        tick(); tick();
        in_oe = 1; port_sel = 0;
        #1;
        check("read in0 old", 32'(bus_out_b), 32'h00C3);
        tick();
        in_oe = 0; in_strobe = 2'b00; stat_oe = 1;
        #1;
        check("full kept", 32'(bus_out_b), 32'h0010);
        stat_oe = 0;

        // Out-of-range select: read zero, no stall, no state change
        in_oe = 1; port_sel = 5; out_we = 1; bus_in = 16'h00EE;
        #1;
        check("sel5 read", 32'(bus_out_b), 32'h0000);
        check("sel5 stall", 32'(stall_b), 32'h0);
        tick();
        in_oe = 0; out_we = 0;
        check("sel5 no write", 32'(out_valid_b), 32'h0);
        in_oe = 1; port_sel = 0;
        #1;
        check("in0 new data", 32'(bus_out_b), 32'h00D4);
        in_oe = 0; stat_oe = 1;
        #1;
        check("sel5 status", 32'(bus_out_b), 32'h0010);

        // Asynchronous reset in the middle of a stalled handshake
        stat_oe = 0; out_we = 1; port_sel = 0; bus_in = 16'h0099;
        tick();
        bus_in = 16'h00AA; stat_oe = 1;
        #1;
        check("pre-reset stall", 32'(stall_b), 32'h1);
        #1;
        rst = 1;
        #1;
        check("rst stall", 32'(stall_b), 32'h0);
        check("rst valid", 32'(out_valid_b), 32'h0);
        check("rst data", 32'(out_data_b), 32'h0);
        check("rst status", 32'(bus_out_b), 32'h0000);
        out_we = 0; stat_oe = 0;
        tick();
        rst = 0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
